// File: rtl/palette_ram_arbiter_pkg.sv
// rtl/palette_ram_arbiter_pkg.sv - shared types and widths for the palette RAM arbiter
package palette_arb_pkg;

  localparam int PAL_AW   = 13;
  localparam int PAL_DW   = 16;
  localparam int BE_UPPER = 1;
  localparam int BE_LOWER = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2
  } arb_state_t;

endpackage

// File: rtl/palette_ram_arbiter_if.sv
// rtl/palette_ram_arbiter_if.sv - video, CPU and SRAM signals around the palette arbiter
interface palette_ram_arbiter_if;
  import palette_arb_pkg::*;

  logic              ce_pixel;
  logic [PAL_AW-1:0] vid_addr;
  logic [PAL_DW-1:0] vid_data;
  logic              cpu_req;
  logic              cpu_we;
  logic [PAL_AW-1:0] cpu_addr;
  logic [1:0]        cpu_be;
  logic [PAL_DW-1:0] cpu_din;
  logic [PAL_DW-1:0] cpu_dout;
  logic              cpu_ack;
  logic [PAL_AW-1:0] ram_addr;
  logic [PAL_DW-1:0] ram_din;
  logic [PAL_DW-1:0] ram_dout;
  logic [1:0]        ram_we;

  // arbiter side
  modport slave (
    input  ce_pixel, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_be, cpu_din, ram_din,
    output vid_data, cpu_dout, cpu_ack, ram_addr, ram_dout, ram_we
  );

  // video pipeline, CPU and SRAM side
  modport master (
    output ce_pixel, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_be, cpu_din, ram_din,
    input  vid_data, cpu_dout, cpu_ack, ram_addr, ram_dout, ram_we
  );

endinterface

// File: rtl/palette_ram_arbiter.sv
// rtl/palette_ram_arbiter.sv - shares the single-port palette SRAM between pixel lookups and CPU accesses
module palette_ram_arbiter
  import palette_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  palette_ram_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  arb_state_t        state;
  logic [CW-1:0]     starve_cnt;
  logic              starve;
  logic              cpu_slot;
  logic              vid_pend;
  logic              cpu_ack;
  logic [PAL_DW-1:0] cpu_dout;
  logic [PAL_DW-1:0] vid_data;

  assign starve   = (starve_cnt == CW'(STARVE_LIMIT));
  assign cpu_slot = (state == IDLE) & bus.cpu_req & (~bus.ce_pixel | starve);

  assign bus.ram_addr = cpu_slot ? bus.cpu_addr : bus.vid_addr;
  // the FSM sits in IDLE under reset, so the strobes need explicit gating
  assign bus.ram_we   = (cpu_slot & bus.cpu_we & ~reset) ? bus.cpu_be : 2'b00;
  assign bus.ram_dout = bus.cpu_din;
  assign bus.cpu_ack  = cpu_ack;
  assign bus.cpu_dout = cpu_dout;
  assign bus.vid_data = vid_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cpu_ack    <= 1'b0;
      cpu_dout   <= '0;
      vid_data   <= '0;
      vid_pend   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      // a forced CPU slot drops this pixel; vid_data simply holds
      vid_pend <= bus.ce_pixel & ~cpu_slot;
      if (vid_pend) vid_data <= bus.ram_din;

      if (cpu_slot || !bus.cpu_req)
        starve_cnt <= '0;
      else if (state == IDLE && bus.ce_pixel && !starve)
        starve_cnt <= starve_cnt + CW'(1);

      case (state)
        IDLE: begin
          if (cpu_slot) begin
            if (bus.cpu_we) begin
              state   <= ACK;
              cpu_ack <= 1'b1;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          cpu_dout <= bus.ram_din;
          cpu_ack  <= 1'b1;
          state    <= ACK;
        end
        ACK: begin
          if (!bus.cpu_req) begin
            cpu_ack <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
